// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The memory access mode encoding is the one the data memory decodes.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CORE = 2'd1,
        ARB_DBG  = 2'd2,
        ARB_LOCK = 2'd3
    } arb_state_t;

    localparam int unsigned MODE_BITS = 3;
    localparam int unsigned WAIT_W    = 8;

    localparam logic [MODE_BITS-1:0] MODE_BYTE   = 3'b000;
    localparam logic [MODE_BITS-1:0] MODE_HALF   = 3'b001;
    localparam logic [MODE_BITS-1:0] MODE_WORD   = 3'b010;
    localparam logic [MODE_BITS-1:0] MODE_BYTE_U = 3'b100;
    localparam logic [MODE_BITS-1:0] MODE_HALF_U = 3'b101;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear.
// Tracks how long the core has been kept waiting.
module arb_wait_counter #(
    parameter int unsigned MAX   = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(MAX))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter (core vs. debug/loader) with burst lock and core starvation guard.
// Define DMEM_ARB_RR_EN for alternating contention; otherwise debug has fixed priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [MODE_BITS-1:0] core_mode,
    input  logic [WIDTH-1:0]     core_addr,
    input  logic [WIDTH-1:0]     core_wd,
    output logic                 core_gnt,
    output logic                 core_stall,
    output logic                 core_rvalid,
    output logic [WIDTH-1:0]     core_rd,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic                 dbg_lock,
    input  logic [MODE_BITS-1:0] dbg_mode,
    input  logic [WIDTH-1:0]     dbg_addr,
    input  logic [WIDTH-1:0]     dbg_wd,
    output logic                 dbg_gnt,
    output logic                 dbg_rvalid,
    output logic [WIDTH-1:0]     dbg_rd,
    output logic                 mem_we,
    output logic [MODE_BITS-1:0] mem_mode,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     mem_wd,
    input  logic [WIDTH-1:0]     mem_rd,
    output logic [1:0]           owner
);

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_inc;
    logic              starved;

`ifdef DMEM_ARB_RR_EN
    logic rr_core_next;

    // Contention goes to whoever was not granted last; core first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_core_next <= 1'b1;
        end else if (core_gnt) begin
            rr_core_next <= 1'b0;
        end else if (dbg_gnt) begin
            rr_core_next <= 1'b1;
        end
    end
`endif

    // Grant decision: starvation guard, then lock, then contention policy.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        starved  = core_req && (wait_cnt == WAIT_W'(MAX_WAIT));
        if (!rst) begin
            if (starved) begin
                core_gnt = 1'b1;
            end else if ((state == ARB_LOCK) && dbg_req) begin
                dbg_gnt = 1'b1;
            end else if (core_req && dbg_req) begin
`ifdef DMEM_ARB_RR_EN
                core_gnt = rr_core_next;
                dbg_gnt  = !rr_core_next;
`else
                dbg_gnt  = 1'b1;
`endif
            end else begin
                core_gnt = core_req;
                dbg_gnt  = dbg_req;
            end
        end
    end

    assign core_stall = core_req && !core_gnt;
    assign wait_inc   = core_req && !core_gnt;
    assign owner      = 2'(state);

    arb_wait_counter #(
        .MAX   (MAX_WAIT),
        .CNT_W (WAIT_W)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .inc   (wait_inc),
        .clr   (!wait_inc),
        .count (wait_cnt)
    );

    // Memory port follows the granted requester, idles at zero.
    always_comb begin
        mem_we   = 1'b0;
        mem_mode = '0;
        mem_addr = '0;
        mem_wd   = '0;
        if (core_gnt) begin
            mem_we   = core_we;
            mem_mode = core_mode;
            mem_addr = core_addr;
            mem_wd   = core_wd;
        end else if (dbg_gnt) begin
            mem_we   = dbg_we;
            mem_mode = dbg_mode;
            mem_addr = dbg_addr;
            mem_wd   = dbg_wd;
        end
    end

    // State records the last grant; a lock survives a starvation grant to the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else if (state == ARB_LOCK) begin
            state <= (dbg_req && dbg_lock) ? ARB_LOCK : ARB_IDLE;
        end else if (core_gnt) begin
            state <= ARB_CORE;
        end else if (dbg_gnt) begin
            state <= dbg_lock ? ARB_LOCK : ARB_DBG;
        end else begin
            state <= ARB_IDLE;
        end
    end

    // Read data returns one cycle after a granted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
            core_rd     <= '0;
            dbg_rd      <= '0;
        end else begin
            core_rvalid <= core_gnt && !core_we;
            dbg_rvalid  <= dbg_gnt && !dbg_we;
            if (core_gnt && !core_we) begin
                core_rd <= mem_rd;
            end
            if (dbg_gnt && !dbg_we) begin
                dbg_rd <= mem_rd;
            end
        end
    end

endmodule
